// File: rtl/raster_scan_controller.sv
// raster_scan_controller
//   Handles one triangle at a time for an external combinational inside-tester.
//   It latches the three vertices and computes the screen-clamped bounding box
//   and the doubled signed area. It then walks the box from the top row down,
//   left to right within a row, and streams the tested pixels out with backpressure.
//
// Ports
//   Clock, Reset_n        rising-edge clock, asynchronous active-low reset
//   TriValid/TriReady     triangle offer; TriReady is high only in IDLE
//   TriBus  [6W]          {P1X,P1Y,P2X,P2Y,P3X,P3Y}
//   VertBus [6W]          latched vertices, same packing, held until next accept
//   TestX/TestY [W]       pixel under test (hold last value outside SCAN)
//   TestIn                tester verdict for (TestX,TestY), same cycle
//   PixValid/PixReady     output pixel handshake
//   PixX/PixY [W]         emitted pixel
//   PixInside             tester verdict for the emitted pixel
//   Busy                  high in every state except IDLE
//   Done                  one-cycle pulse when a triangle finishes
//   DbgState [3]          current FSM state encoding
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Once the producer raises valid, it keeps valid and payload stable
// until that transfer. The producer does not wait for ready before raising valid.
module raster_scan_controller #(
  parameter int W        = 12,
  parameter int MAX_X    = 40,
  parameter int MAX_Y    = 50,
  parameter bit EMIT_ALL = 1'b0
) (
  input  logic           Clock,
  input  logic           Reset_n,
  input  logic           TriValid,
  output logic           TriReady,
  input  logic [6*W-1:0] TriBus,
  output logic [6*W-1:0] VertBus,
  output logic [W-1:0]   TestX,
  output logic [W-1:0]   TestY,
  input  logic           TestIn,
  output logic           PixValid,
  input  logic           PixReady,
  output logic [W-1:0]   PixX,
  output logic [W-1:0]   PixY,
  output logic           PixInside,
  output logic           Busy,
  output logic           Done,
  output logic [2:0]     DbgState
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_BBOX = 3'd1,
    S_SCAN = 3'd2,
    S_EMIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [W-1:0] MAX_XC = W'(MAX_X);
  localparam logic [W-1:0] MAX_YC = W'(MAX_Y);

  state_t           state;
  logic [6*W-1:0]   vert;
  logic [W-1:0]     xmin, xmax, ymin;
  logic [W-1:0]     cur_x, cur_y;
  logic [W-1:0]     test_x_q, test_y_q;
  logic [W-1:0]     pix_x_q, pix_y_q;
  logic             pix_in_q, pix_valid_q;
  logic             tri_ready_q, busy_q, done_q;

  // Vertex fields of the latched triangle
  logic [W-1:0] p1x, p1y, p2x, p2y, p3x, p3y;
  assign p1x = vert[6*W-1 -: W];
  assign p1y = vert[5*W-1 -: W];
  assign p2x = vert[4*W-1 -: W];
  assign p2y = vert[3*W-1 -: W];
  assign p3x = vert[2*W-1 -: W];
  assign p3y = vert[1*W-1 -: W];

  function automatic logic [W-1:0] min3(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] c);
    logic [W-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic [W-1:0] max3(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic [W-1:0] c);
    logic [W-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bounding box, evaluated from the latched vertices during BBOX
  logic [W-1:0] bb_xmin, bb_ymin, bb_xmax_raw, bb_ymax_raw, bb_xmax, bb_ymax;
  assign bb_xmin     = min3(p1x, p2x, p3x);
  assign bb_ymin     = min3(p1y, p2y, p3y);
  assign bb_xmax_raw = max3(p1x, p2x, p3x);
  assign bb_ymax_raw = max3(p1y, p2y, p3y);
  assign bb_xmax     = (bb_xmax_raw > MAX_XC) ? MAX_XC : bb_xmax_raw;
  assign bb_ymax     = (bb_ymax_raw > MAX_YC) ? MAX_YC : bb_ymax_raw;

  // Doubled signed area at full precision. A zero value means the vertices are collinear.
  logic signed [W:0]     d21x, d31y, d31x, d21y;
  logic signed [2*W+1:0] prod_a, prod_b;
  logic signed [2*W+2:0] a2;
  assign d21x   = $signed({1'b0, p2x}) - $signed({1'b0, p1x});
  assign d31y   = $signed({1'b0, p3y}) - $signed({1'b0, p1y});
  assign d31x   = $signed({1'b0, p3x}) - $signed({1'b0, p1x});
  assign d21y   = $signed({1'b0, p2y}) - $signed({1'b0, p1y});
  assign prod_a = (2*W+2)'(d21x) * (2*W+2)'(d31y);
  assign prod_b = (2*W+2)'(d31x) * (2*W+2)'(d21y);
  assign a2     = (2*W+3)'(prod_a) - (2*W+3)'(prod_b);

  logic skip_tri;
  assign skip_tri = (a2 == '0) || (bb_xmin > MAX_XC) || (bb_ymin > MAX_YC);

  // The scan ends at the bottom-right corner of the box.
  logic last_pix;
  assign last_pix = (cur_x == xmax) && (cur_y == ymin);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= S_IDLE;
      vert        <= '0;
      xmin        <= '0;
      xmax        <= '0;
      ymin        <= '0;
      cur_x       <= '0;
      cur_y       <= '0;
      test_x_q    <= '0;
      test_y_q    <= '0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_in_q    <= 1'b0;
      pix_valid_q <= 1'b0;
      tri_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (TriValid) begin
            vert        <= TriBus;
            tri_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state       <= S_BBOX;
          end
        end
        S_BBOX: begin
          xmin <= bb_xmin;
          xmax <= bb_xmax;
          ymin <= bb_ymin;
          if (skip_tri) begin
            done_q <= 1'b1;
            state  <= S_DONE;
          end else begin
            cur_x <= bb_xmin;
            cur_y <= bb_ymax;
            state <= S_SCAN;
          end
        end
        S_SCAN: begin
          test_x_q <= cur_x;
          test_y_q <= cur_y;
          if (EMIT_ALL || TestIn) begin
            pix_x_q     <= cur_x;
            pix_y_q     <= cur_y;
            pix_in_q    <= TestIn;
            pix_valid_q <= 1'b1;
            state       <= S_EMIT;
          end else if (last_pix) begin
            done_q <= 1'b1;
            state  <= S_DONE;
          end else begin
            if (cur_x == xmax) begin
              cur_x <= xmin;
              cur_y <= cur_y - 1'b1;
            end else begin
              cur_x <= cur_x + 1'b1;
            end
          end
        end
        S_EMIT: begin
          if (PixReady) begin
            pix_valid_q <= 1'b0;
            if (last_pix) begin
              done_q <= 1'b1;
              state  <= S_DONE;
            end else begin
              if (cur_x == xmax) begin
                cur_x <= xmin;
                cur_y <= cur_y - 1'b1;
              end else begin
                cur_x <= cur_x + 1'b1;
              end
              state <= S_SCAN;
            end
          end
        end
        S_DONE: begin
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          tri_ready_q <= 1'b1;
          state       <= S_IDLE;
        end
        default: begin
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          pix_valid_q <= 1'b0;
          tri_ready_q <= 1'b1;
          state       <= S_IDLE;
        end
      endcase
    end
  end

  // Live coordinate while scanning so the tester verdict lands in the same cycle.
  assign TestX     = (state == S_SCAN) ? cur_x : test_x_q;
  assign TestY     = (state == S_SCAN) ? cur_y : test_y_q;
  assign VertBus   = vert;
  assign TriReady  = tri_ready_q;
  assign PixValid  = pix_valid_q;
  assign PixX      = pix_x_q;
  assign PixY      = pix_y_q;
  assign PixInside = pix_in_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign DbgState  = state;

endmodule
